// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and a small colour palette for the VGA display path.
package vga_pkg;

  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_DISP  = 640;
  localparam int H_FRONT = 16;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_DISP  = 480;
  localparam int V_FRONT = 10;

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  typedef logic [11:0] rgb_t;

  localparam rgb_t RED    = 12'hF00;
  localparam rgb_t GREEN  = 12'h0F0;
  localparam rgb_t BLUE   = 12'h00F;
  localparam rgb_t WHITE  = 12'hFFF;
  localparam rgb_t BLACK  = 12'h000;
  localparam rgb_t YELLOW = 12'hFF0;
  localparam rgb_t CYAN   = 12'h0FF;
  localparam rgb_t ROYAL  = 12'h36E;

endpackage

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical position counters; vcnt advances only when the line wraps.
module vga_timing_cnt
  import vga_pkg::*;
#(
  parameter int H_LEN = H_TOTAL,
  parameter int V_LEN = V_TOTAL
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       line_end
);

  localparam logic [9:0] H_LAST = 10'(H_LEN - 1);
  localparam logic [9:0] V_LAST = 10'(V_LEN - 1);

  assign line_end = (hcnt == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

endmodule

// File: rtl/vga_driver.sv
// VGA timing generator: issues pixel requests one clock ahead and registers sync/blank/colour to the pins.
module vga_driver #(
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BACK  = vga_pkg::H_BACK,
  parameter int H_DISP  = vga_pkg::H_DISP,
  parameter int H_FRONT = vga_pkg::H_FRONT,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BACK  = vga_pkg::V_BACK,
  parameter int V_DISP  = vga_pkg::V_DISP,
  parameter int V_FRONT = vga_pkg::V_FRONT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] vga_data,
  output logic        vga_req,
  output logic [9:0]  vga_xpos,
  output logic [9:0]  vga_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [11:0] vga_rgb,
  output logic        vga_frame
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  localparam logic [10:0] H_ACT_LO = 11'(HA);
  localparam logic [10:0] H_ACT_HI = 11'(HA + H_DISP);
  localparam logic [9:0]  V_ACT_LO = 10'(VA);
  localparam logic [9:0]  V_ACT_HI = 10'(VA + V_DISP);
  localparam logic [9:0]  H_SYNC_L = 10'(H_SYNC);
  localparam logic [9:0]  V_SYNC_L = 10'(V_SYNC);
  localparam logic [9:0]  X_OFS    = 10'(HA - 1);

  function automatic logic act(input logic [10:0] h, input logic [9:0] v);
    return (h >= H_ACT_LO) && (h < H_ACT_HI) && (v >= V_ACT_LO) && (v < V_ACT_HI);
  endfunction

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        line_end;
  logic [10:0] hnext;
  logic        cur_act;

  vga_timing_cnt #(
    .H_LEN(H_TOTAL),
    .V_LEN(V_TOTAL)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .line_end(line_end)
  );

  // hnext is 11 bits so the last column of a line never aliases into the active window
  assign hnext   = {1'b0, hcnt} + 11'd1;
  assign cur_act = act({1'b0, hcnt}, vcnt);

  always_comb begin
    vga_req  = !line_end && act(hnext, vcnt);
    vga_xpos = '0;
    vga_ypos = '0;
    if (vga_req) begin
      vga_xpos = hcnt - X_OFS;
      vga_ypos = vcnt - V_ACT_LO;
    end
  end

  // Data outside the active window is never sampled, so an undriven responder cannot leak to the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
      vga_de    <= 1'b0;
      vga_rgb   <= '0;
      vga_frame <= 1'b0;
    end else begin
      vga_hs    <= ~(hcnt < H_SYNC_L);
      vga_vs    <= ~(vcnt < V_SYNC_L);
      vga_de    <= cur_act;
      vga_rgb   <= cur_act ? vga_data : '0;
      vga_frame <= (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_driver.sv
// Bench for vga_driver: a full-size and a shrunken-timing instance checked every clock against an arithmetic position model.
module tb_vga_driver;

  logic        clk;
  logic        rst_n;
  logic        mode;
  longint      k;
  int          n_vec = 0;
  int          n_err = 0;
  int          cfg [2][8];

  logic [11:0] data0, data1, rgb0, rgb1;
  logic        req0, hs0, vs0, de0, fr0;
  logic        req1, hs1, vs1, de1, fr1;
  logic [9:0]  x0, y0, x1, y1;

  vga_driver u_std (
    .clk(clk), .rst_n(rst_n), .vga_data(data0), .vga_req(req0),
    .vga_xpos(x0), .vga_ypos(y0), .vga_hs(hs0), .vga_vs(vs0),
    .vga_de(de0), .vga_rgb(rgb0), .vga_frame(fr0)
  );

  vga_driver #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(16), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_DISP(8),  .V_FRONT(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .vga_data(data1), .vga_req(req1),
    .vga_xpos(x1), .vga_ypos(y1), .vga_hs(hs1), .vga_vs(vs1),
    .vga_de(de1), .vga_rgb(rgb1), .vga_frame(fr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clocks since reset release; outputs seen at a negedge reflect position k-1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Responder: registered answer to each request, random garbage otherwise
  always @(posedge clk) begin
    data0 <= mode ? 12'hFFF : (req0 ? {y0[3:0], x0[7:0]} : 12'($urandom));
    data1 <= mode ? 12'hFFF : (req1 ? {y1[3:0], x1[7:0]} : 12'($urandom));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at k=%0d", tag, got, exp, k);
    end
  endtask

  function automatic bit in_win(input int h, input int v, input int ha, input int hd,
                                input int va, input int vd);
    return (h >= ha) && (h < ha + hd) && (v >= va) && (v < va + vd);
  endfunction

  task automatic check_dut(input int c, input logic hs, input logic vs, input logic de,
                           input logic fr, input logic req, input logic [9:0] x,
                           input logic [9:0] y, input logic [11:0] rgb);
    int htot, vtot, ha, va, h, v, xx, yy;
    logic e_hs, e_vs, e_de, e_fr, e_req;
    logic [9:0] e_x, e_y;
    logic [11:0] e_rgb;
    string p;
    p    = (c == 0) ? "std" : "small";
    htot = cfg[c][0] + cfg[c][1] + cfg[c][2] + cfg[c][3];
    vtot = cfg[c][4] + cfg[c][5] + cfg[c][6] + cfg[c][7];
    ha   = cfg[c][0] + cfg[c][1];
    va   = cfg[c][4] + cfg[c][5];
    if (k == 0) begin
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fr = 1'b0; e_rgb = 12'h000;
    end else begin
      h     = int'((k - 1) % htot);
      v     = int'(((k - 1) / htot) % vtot);
      e_hs  = !(h < cfg[c][0]);
      e_vs  = !(v < cfg[c][4]);
      e_de  = in_win(h, v, ha, cfg[c][2], va, cfg[c][6]);
      e_fr  = (h == 0) && (v == 0);
      xx    = h - ha;
      yy    = v - va;
      e_rgb = !e_de ? 12'h000 : (mode ? 12'hFFF : {yy[3:0], xx[7:0]});
    end
    h     = int'(k % htot);
    v     = int'((k / htot) % vtot);
    e_req = in_win(h + 1, v, ha, cfg[c][2], va, cfg[c][6]);
    xx    = h + 1 - ha;
    yy    = v - va;
    e_x   = e_req ? xx[9:0] : 10'd0;
    e_y   = e_req ? yy[9:0] : 10'd0;
    check({p, ".hs"},    32'(hs),  32'(e_hs));
    check({p, ".vs"},    32'(vs),  32'(e_vs));
    check({p, ".de"},    32'(de),  32'(e_de));
    check({p, ".frame"}, 32'(fr),  32'(e_fr));
    check({p, ".rgb"},   32'(rgb), 32'(e_rgb));
    check({p, ".req"},   32'(req), 32'(e_req));
    check({p, ".xpos"},  32'(x),   32'(e_x));
    check({p, ".ypos"},  32'(y),   32'(e_y));
  endtask

  task automatic check_all();
    check_dut(0, hs0, vs0, de0, fr0, req0, x0, y0, rgb0);
    check_dut(1, hs1, vs1, de1, fr1, req1, x1, y1, rgb1);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    int col;
    cfg = '{'{96, 48, 640, 16, 2, 33, 480, 10}, '{4, 3, 16, 2, 2, 3, 8, 2}};
    mode  = 1'b0;
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;

    // Pattern phase long enough to reach active lines of the full-size timing
    col = int'($urandom_range(799, 0));
    run(40 * 800 + col);

    // Asynchronous reset in the middle of a line
    #2 rst_n = 1'b0;
    #1 check_all();
    mode = 1'b1;
    run(int'($urandom_range(4, 2)));
    rst_n = 1'b1;

    // Constant-white responder: colour must appear only under display enable
    run(40 * 800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
